// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU-wide constants
package cpu_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP          = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bundle: redirect, imem and decode-queue signals
interface fetch_unit_if import cpu_pkg::*; #(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
);

  logic                         redirect_valid;
  logic [XLEN-1:0]              redirect_pc;
  logic                         imem_req;
  logic [XLEN-1:0]              imem_addr;
  logic [31:0]                  imem_instr;
  logic                         deq_ready;
  logic                         deq_valid;
  logic [31:0]                  deq_instr;
  logic [XLEN-1:0]              deq_pc_plus4;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    input  redirect_valid, redirect_pc, imem_instr, deq_ready,
    output imem_req, imem_addr, deq_valid, deq_instr, deq_pc_plus4, count
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_instr, deq_ready,
    input  imem_req, imem_addr, deq_valid, deq_instr, deq_pc_plus4, count
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two instruction queue with flush
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Callers never push when full or pop when empty, so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing, imem request/response tracking and redirect handling
module fetch_unit import cpu_pkg::*; #(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              IMEM_SYNC = 0
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int W  = XLEN + 32;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            req;
  logic            push;
  logic            pop;
  logic            valid;
  logic [W-1:0]    push_data;
  logic [W-1:0]    head_data;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;

  // Only registered state feeds the capacity check, keeping deq_ready off the request path.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign req       = !reset && !bus.redirect_valid && (occupancy < (CW+1)'(DEPTH));

  always_comb begin
    push      = req;
    push_data = {pc, bus.imem_instr};
    if (IMEM_SYNC != 0) begin
      push      = inflight && !bus.redirect_valid;
      push_data = {inflight_pc, bus.imem_instr};
    end
  end

  assign valid = !reset && (count != '0);
  assign pop   = valid && bus.deq_ready && !bus.redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      pc       <= bus.redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= (IMEM_SYNC != 0) && req;
      if (req) begin
        pc          <= pc + XLEN'(4);
        inflight_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head_data (head_data),
    .count     (count)
  );

  assign {head_pc, head_instr} = head_data;

  assign bus.imem_req     = req;
  assign bus.imem_addr    = pc;
  assign bus.deq_valid    = valid;
  assign bus.deq_instr    = valid ? head_instr : NOP;
  assign bus.deq_pc_plus4 = valid ? head_pc + XLEN'(4) : '0;
  assign bus.count        = count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit (combinational, registered and wrapping configurations)
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fetch_unit_if #(.XLEN(32), .DEPTH(4)) bus0 ();
  fetch_unit_if #(.XLEN(32), .DEPTH(4)) bus1 ();
  fetch_unit_if #(.XLEN(32), .DEPTH(4)) bus2 ();

  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .IMEM_SYNC(0))
    u0 (.clk(clk), .reset(reset), .bus(bus0));
  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .IMEM_SYNC(1))
    u1 (.clk(clk), .reset(reset), .bus(bus1));
  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .IMEM_SYNC(0))
    u2 (.clk(clk), .reset(reset), .bus(bus2));

  // Instruction memory: word at address a reads as {C0DE, a[15:0]}.
  assign bus0.imem_instr = {16'hC0DE, bus0.imem_addr[15:0]};
  assign bus2.imem_instr = {16'hC0DE, bus2.imem_addr[15:0]};
  always @(posedge clk) bus1.imem_instr <= {16'hC0DE, bus1.imem_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus0.deq_ready = 1'b1; bus0.redirect_valid = 1'b0; bus0.redirect_pc = '0;
    bus1.deq_ready = 1'b1; bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0;
    bus2.deq_ready = 1'b1; bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0;

    // reset state
    tick; tick;
    check("rst_req",   bus0.imem_req,  0);
    check("rst_valid", bus0.deq_valid, 0);
    check("rst_instr", bus0.deq_instr, 32'h0000_0013);
    check("rst_pc4",   bus0.deq_pc_plus4, 0);
    check("rst_count", bus0.count,     0);
    check("rst_addr",  bus0.imem_addr, 0);

    // streaming with deq_ready=1
    reset = 1'b0; #1;
    check("a_req_c1",   bus0.imem_req,  1);
    check("a_valid_c1", bus0.deq_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("a_valid", bus0.deq_valid, 1);
      check("a_pc4",   bus0.deq_pc_plus4, 32'(4 * (k + 1)));
      check("a_instr", bus0.deq_instr, {16'hC0DE, 16'(4 * k)});
      check("a_count", bus0.count, 1);
    end

    // mid-stream reset, then pop+push at count 2, then backpressure to full
    reset = 1'b1; bus0.deq_ready = 1'b0;
    tick;
    check("b_rst_count", bus0.count,     0);
    check("b_rst_valid", bus0.deq_valid, 0);
    reset = 1'b0; #1;
    check("b_addr_first", bus0.imem_addr, 0);
    tick; tick;
    bus0.deq_ready = 1'b1; #1;
    check("b_cnt2",     bus0.count, 2);
    check("b_head_pc4", bus0.deq_pc_plus4, 4);
    tick;
    check("b_cnt2_hold", bus0.count, 2);
    check("b_head2_pc4", bus0.deq_pc_plus4, 8);
    bus0.deq_ready = 1'b0;
    repeat (10) tick;
    check("b_full_count", bus0.count, 4);
    check("b_full_req",   bus0.imem_req, 0);
    check("b_full_addr",  bus0.imem_addr, 20);
    check("b_full_pc4",   bus0.deq_pc_plus4, 8);
    bus0.deq_ready = 1'b1; #1;
    check("b_full_pop_req", bus0.imem_req, 0);
    tick;
    check("b_after_pop_count", bus0.count, 3);
    check("b_drain_pc4", bus0.deq_pc_plus4, 12);
    for (int k = 1; k < 6; k++) begin
      tick;
      check("b_drain_pc4",   bus0.deq_pc_plus4, 32'(12 + 4 * k));
      check("b_drain_count", bus0.count, 3);
    end

    // redirect with 3 queued entries
    check("c_pre_count", bus0.count, 3);
    bus0.redirect_valid = 1'b1; bus0.redirect_pc = 32'h100; #1;
    check("c_redir_req", bus0.imem_req, 0);
    tick;
    bus0.redirect_valid = 1'b0; #1;
    check("c_count", bus0.count, 0);
    check("c_valid", bus0.deq_valid, 0);
    check("c_pc4",   bus0.deq_pc_plus4, 0);
    check("c_instr", bus0.deq_instr, 32'h0000_0013);
    check("c_addr",  bus0.imem_addr, 32'h100);
    check("c_req",   bus0.imem_req, 1);
    tick;
    check("c_next_pc4",   bus0.deq_pc_plus4, 32'h104);
    check("c_next_instr", bus0.deq_instr, 32'hC0DE_0100);

    // registered imem: redirect the cycle after a request
    reset = 1'b1;
    tick;
    reset = 1'b0; #1;
    check("d_req_c1",  bus1.imem_req, 1);
    check("d_addr_c1", bus1.imem_addr, 0);
    tick;
    check("d_valid_c2", bus1.deq_valid, 0);
    bus1.redirect_valid = 1'b1; bus1.redirect_pc = 32'h100; #1;
    check("d_redir_req", bus1.imem_req, 0);
    tick;
    bus1.redirect_valid = 1'b0; #1;
    check("d_count", bus1.count, 0);
    check("d_valid", bus1.deq_valid, 0);
    check("d_addr",  bus1.imem_addr, 32'h100);
    check("d_req",   bus1.imem_req, 1);
    tick;
    check("d_stale_valid", bus1.deq_valid, 0);
    check("d_stale_count", bus1.count, 0);
    tick;
    check("d_first_valid", bus1.deq_valid, 1);
    check("d_first_pc4",   bus1.deq_pc_plus4, 32'h104);
    check("d_first_instr", bus1.deq_instr, 32'hC0DE_0100);
    tick;
    check("d_second_pc4",   bus1.deq_pc_plus4, 32'h108);
    check("d_second_instr", bus1.deq_instr, 32'hC0DE_0104);
    check("d_second_count", bus1.count, 1);

    // PC wrap from RESET_PC 0xFFFFFFF8
    reset = 1'b1;
    tick;
    reset = 1'b0; #1;
    check("e_addr0", bus2.imem_addr, 32'hFFFF_FFF8);
    check("e_req0",  bus2.imem_req, 1);
    tick;
    check("e_addr1", bus2.imem_addr, 32'hFFFF_FFFC);
    check("e_pc4_0", bus2.deq_pc_plus4, 32'hFFFF_FFFC);
    tick;
    check("e_addr2",  bus2.imem_addr, 32'h0000_0000);
    check("e_valid",  bus2.deq_valid, 1);
    check("e_pc4_1",  bus2.deq_pc_plus4, 32'h0000_0000);
    check("e_instr1", bus2.deq_instr, 32'hC0DE_FFFC);
    tick;
    check("e_pc4_2",  bus2.deq_pc_plus4, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: address/PC width.
REQ-002 SHALL have parameter DEPTH, default 4: instruction queue entries, power of two, >= 2.
REQ-003 SHALL have parameter RESET_PC, default 0: PC value after reset.
REQ-004 SHALL have parameter IMEM_SYNC, default 0: 0 = combinational imem read, 1 = registered imem read with 1-cycle latency.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port redirect_valid, input, 1: branch taken / flush request from EX.
REQ-008 SHALL have port redirect_pc, input, XLEN: redirect target.
REQ-009 SHALL have port imem_req, output, 1: fetch issued this cycle.
REQ-010 SHALL have port imem_addr, output, XLEN: fetch address, equal to current PC.
REQ-011 SHALL have port imem_instr, input, 32: instruction data (same cycle if IMEM_SYNC=0, next cycle if 1).
REQ-012 SHALL have port deq_ready, input, 1: decode accepts (driven as ~stall).
REQ-013 SHALL have port deq_valid, output, 1: queue head is valid.
REQ-014 SHALL have port deq_instr, output, 32: head instruction.
REQ-015 SHALL have port deq_pc_plus4, output, XLEN: head PC + 4.
REQ-016 SHALL have port count, output, $clog2(DEPTH+1): occupied entries.

Function
REQ-017 SHALL issue imem_req when not reset, not redirect_valid, and (count + inflight) < DEPTH; inflight is 0 when IMEM_SYNC=0.
REQ-018 SHALL advance PC by 4 (modulo 2^XLEN, wrap allowed) on every issued request.
REQ-019 SHALL, for IMEM_SYNC=0, enqueue {imem_instr, PC} in the cycle of the request.
REQ-020 SHALL, for IMEM_SYNC=1, track one in-flight flag plus its PC and enqueue imem_instr the cycle after the request.
REQ-021 SHALL give minimum latency request -> deq_valid of 1 cycle (IMEM_SYNC=0) or 2 cycles (IMEM_SYNC=1); no empty-queue bypass.
REQ-022 SHALL pop the head when deq_valid && deq_ready; enqueue and pop in the same cycle leave count unchanged.
REQ-023 SHALL not issue a request when full, even if a pop occurs that cycle.
REQ-024 SHALL drive deq_instr = NOP (0x00000013) and deq_pc_plus4 = 0 whenever deq_valid = 0.
REQ-025 SHALL, on redirect_valid, next cycle: PC = redirect_pc, count = 0, inflight cleared, any response returning in that following cycle discarded; a pop coinciding with redirect is ignored.
REQ-026 SHALL give redirect priority over request, enqueue and pop in the same cycle.
REQ-027 SHALL drive deq_pc_plus4 computed from the stored entry PC, never from the live PC.

Reset
REQ-028 SHALL, while reset = 1: PC = RESET_PC, count = 0, read/write pointers = 0, inflight = 0, imem_req = 0, deq_valid = 0, deq_instr = NOP.
REQ-029 SHALL, when reset asserts mid-stream, discard all queued and in-flight instructions; the first request after reset is at RESET_PC.

Structure
REQ-030 SHALL take the NOP constant and XLEN default from the shared package cpu_pkg.
REQ-031 SHALL implement the queue as sub-module fetch_fifo (parameters WIDTH, DEPTH; push/pop/flush/count), entry = {pc, instr}.
REQ-032 SHALL keep PC, in-flight tracking and redirect logic in fetch_unit; no combinational path from deq_ready to imem_req.

Verification
REQ-033 SHALL cover: reset, deq_ready = 1, IMEM_SYNC=0 -> deq_pc_plus4 sequence 4, 8, 12, ...; deq_valid first high on cycle 2.
REQ-034 SHALL cover: deq_ready = 0 for 10 cycles, DEPTH=4 -> count saturates at 4, imem_req = 0 while full, no entries lost after release.
REQ-035 SHALL cover: redirect_valid with redirect_pc = 0x100 while 3 entries are queued -> next cycle count = 0, deq_valid = 0; first fetch at 0x100; next deq_pc_plus4 = 0x104.
REQ-036 SHALL cover: IMEM_SYNC=1, redirect in the cycle after a request -> stale response dropped; queue holds only instructions from 0x100 onward.
REQ-037 SHALL cover: simultaneous pop and enqueue at count = 2 -> count stays 2; at full with pop -> count becomes 3, no request that cycle.
REQ-038 SHALL cover: RESET_PC = 0xFFFFFFF8, XLEN = 32 -> PCs fetched 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
